ps2_decoder: RTL and testbench

PS2_DECODER -- requirements
Module: ps2_decoder

---
 rtl/ps2_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ps2_decoder.sv
// ps2_decoder -- receive-only PS/2 keyboard decoder.
//
// Synchronizes the raw PS/2 clock/data lines, assembles 11-bit frames on
// PS/2 clock falling edges, validates start/parity/stop, tracks the E0
// (extended) and F0 (break) prefixes, and presents the last make code with
// its ASCII translation. The PS/2 lines are only ever read.
//
// Ports:
//   clk            in   system clock (rising edge)
//   reset_n        in   asynchronous active-low reset
//   ps2_clk_async  in   raw PS/2 clock
//   ps2_data_async in   raw PS/2 data
//   scan_code      out  last accepted make code (prefixes stripped)
//   ascii_code     out  ASCII of last make code, 0x00 if unmapped
//   key_pressed    out  high while the key in scan_code is held
//   key_released   out  one-clk pulse on any break code
//
// Parameter TIMEOUT_CYCLES: idle clk cycles after which a partial frame is
// dropped.
//
// Optional build macro PS2_SHIFT_MAP_EN: track left/right shift and map
// letters to uppercase and digits to their shifted symbols while held.

module ps2_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Synchronizers plus one extra stage of the clock for edge detection.
  logic       clk_s1_q, clk_s2_q, clk_prev_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fall;

  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    scan_q, scan_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          pressed_q, pressed_d;
  logic          released_q, released_d;
  logic [7:0]    rx_byte;
  logic          shift_held;

`ifdef PS2_SHIFT_MAP_EN
  logic shift_q, shift_d;
  assign shift_held = shift_q;
`else
  assign shift_held = 1'b0;
`endif

  function automatic logic [7:0] ascii_map(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = shift ? ")" : "0";
      8'h16: a = shift ? "!" : "1";
      8'h1E: a = shift ? "@" : "2";
      8'h26: a = shift ? "#" : "3";
      8'h25: a = shift ? "$" : "4";
      8'h2E: a = shift ? "%" : "5";
      8'h36: a = shift ? "^" : "6";
      8'h3D: a = shift ? "&" : "7";
      8'h3E: a = shift ? "*" : "8";
      8'h46: a = shift ? "(" : "9";
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
      8'h0D: a = 8'h09;  8'h76: a = 8'h1B;
      default: a = 8'h00;
    endcase
    // Lowercase letters occupy 0x61..0x7A; uppercase is 0x20 below.
    if (shift && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    return a;
  endfunction

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign rx_byte = frame_q[8:1];

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    scan_d     = scan_q;
    ascii_d    = ascii_q;
    pressed_d  = pressed_q;
    released_d = 1'b0;
`ifdef PS2_SHIFT_MAP_EN
    shift_d    = shift_q;
`endif

    if (fall) begin
      idle_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        // Stop bit is the live data sample; frame_q holds start..parity.
        bit_cnt_d = '0;
        if (!frame_q[0] && dat_s2_q && (^frame_q[9:1])) begin
          if (rx_byte == 8'hE0) begin
            ext_d = 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q) begin
              released_d = 1'b1;
              if (rx_byte == scan_q) pressed_d = 1'b0;
`ifdef PS2_SHIFT_MAP_EN
              if (!ext_q && (rx_byte == 8'h12 || rx_byte == 8'h59)) shift_d = 1'b0;
`endif
            end else begin
              scan_d    = rx_byte;
              ascii_d   = ext_q ? 8'h00 : ascii_map(rx_byte, shift_held);
              pressed_d = 1'b1;
`ifdef PS2_SHIFT_MAP_EN
              if (!ext_q && (rx_byte == 8'h12 || rx_byte == 8'h59)) shift_d = 1'b1;
`endif
            end
          end
        end
      end else if (bit_cnt_q != 4'd0 || !dat_s2_q) begin
        // A high level in the start slot is ignored so reception resyncs
        // on the next real start bit.
        frame_d   = {dat_s2_q, frame_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_cnt_q == TIMEOUT_LAST) begin
        bit_cnt_d  = '0;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      scan_q     <= 8'h00;
      ascii_q    <= 8'h00;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
`ifdef PS2_SHIFT_MAP_EN
      shift_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      clk_s1_q   <= ps2_clk_async;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_async;
      dat_s2_q   <= dat_s1_q;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      scan_q     <= scan_d;
      ascii_q    <= ascii_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
`ifdef PS2_SHIFT_MAP_EN
      shift_q    <= shift_d;
`endif
    end
  end

  assign scan_code    = scan_q;
  assign ascii_code   = ascii_q;
  assign key_pressed  = pressed_q;
  assign key_released = released_q;

endmodule

// File: tb/tb_ps2_decoder.sv
// Directed testbench for ps2_decoder: bit-bangs PS/2 frames and checks the
// decoded outputs against hand-computed values.
module tb_ps2_decoder;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 15;   // clk cycles per PS/2 clock half period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code, ascii_code;
  logic       key_pressed, key_released;

  int checks = 0;
  int failures = 0;
  int rel_pulses = 0;
  int rel_base;

  ps2_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2_clk_async  (ps2_clk),
    .ps2_data_async (ps2_data),
    .scan_code      (scan_code),
    .ascii_code     (ascii_code),
    .key_pressed    (key_pressed),
    .key_released   (key_released)
  );

  always #5 clk = ~clk;

  // Count clk cycles with key_released high, sampled away from the edge.
  always @(negedge clk) if (key_released === 1'b1) rel_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send the first nbits of a frame: start, data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, (par_ok ? ~^b : ^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, 11);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_scan", scan_code, 8'h00);
    check("reset_ascii", ascii_code, 8'h00);
    check("reset_pressed", key_pressed, 1'b0);
    check("reset_released", key_released, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Make 0x1C -> 'a'
    rel_base = rel_pulses;
    send_byte(8'h1C);
    check("make1c_scan", scan_code, 8'h1C);
    check("make1c_ascii", ascii_code, 8'h61);
    check("make1c_pressed", key_pressed, 1'b1);
    check("make1c_released", key_released, 1'b0);
    check("make1c_no_pulse", rel_pulses - rel_base, 0);

    // Break F0 1C -> single pulse, pressed drops, outputs kept
    rel_base = rel_pulses;
    send_byte(8'hF0);
    check("f0_prefix_no_pulse", rel_pulses - rel_base, 0);
    send_byte(8'h1C);
    check("brk1c_pulse_cycles", rel_pulses - rel_base, 1);
    check("brk1c_pressed", key_pressed, 1'b0);
    check("brk1c_ascii", ascii_code, 8'h61);
    check("brk1c_scan", scan_code, 8'h1C);

    // Make 0x32 'b', then bad-parity and bad-stop 0x1C are dropped
    send_byte(8'h32);
    check("make32_ascii", ascii_code, 8'h62);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("badpar_scan", scan_code, 8'h32);
    check("badpar_ascii", ascii_code, 8'h62);
    check("badpar_pressed", key_pressed, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    check("badstop_scan", scan_code, 8'h32);

    // Break of a different key: pulse but pressed stays
    rel_base = rel_pulses;
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("brk_other_pulse", rel_pulses - rel_base, 1);
    check("brk_other_pressed", key_pressed, 1'b1);
    check("brk_other_scan", scan_code, 8'h32);

    // Partial frame, timeout, then valid 0x29 (space)
    send_frame(8'h5A, 1'b1, 1'b1, 6);
    repeat (TIMEOUT + 100) @(posedge clk);
    send_byte(8'h29);
    check("timeout_scan", scan_code, 8'h29);
    check("timeout_ascii", ascii_code, 8'h20);

    // Typematic repeat
    send_byte(8'h29);
    check("repeat_pressed", key_pressed, 1'b1);
    check("repeat_ascii", ascii_code, 8'h20);

    // Extended E0 75
    send_byte(8'hE0);
    check("e0_prefix_scan", scan_code, 8'h29);
    send_byte(8'h75);
    check("ext75_scan", scan_code, 8'h75);
    check("ext75_ascii", ascii_code, 8'h00);
    check("ext75_pressed", key_pressed, 1'b1);

    // Extended flag cleared: plain 0x5A maps to CR
    send_byte(8'h5A);
    check("enter_ascii", ascii_code, 8'h0D);
    send_byte(8'h45);
    check("digit0_ascii", ascii_code, 8'h30);

    // Shift handling
    send_byte(8'h12);
    check("shift_scan", scan_code, 8'h12);
    check("shift_ascii", ascii_code, 8'h00);
    send_byte(8'h1C);
`ifdef PS2_SHIFT_MAP_EN
    check("shifted_a", ascii_code, 8'h41);
`else
    check("unshifted_a", ascii_code, 8'h61);
`endif
    send_byte(8'h16);
`ifdef PS2_SHIFT_MAP_EN
    check("shifted_1", ascii_code, 8'h21);
`else
    check("unshifted_1", ascii_code, 8'h31);
`endif
    send_byte(8'hF0);
    send_byte(8'h12);
    send_byte(8'h16);
    check("shift_rel_1", ascii_code, 8'h31);

    // Reset in the middle of a frame, then fresh reception
    send_frame(8'h76, 1'b1, 1'b1, 4);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_scan", scan_code, 8'h00);
    check("midrst_ascii", ascii_code, 8'h00);
    check("midrst_pressed", key_pressed, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(8'h66);
    check("post_rst_scan", scan_code, 8'h66);
    check("post_rst_ascii", ascii_code, 8'h08);
    check("post_rst_pressed", key_pressed, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
